sd_sector_buffer: RTL
=====================

Name: sd_sector_buffer

Overview:
- Upstream feeder for the SD single-block write engine.
- Collects a byte stream (e.g. captured plate images) into two 512-byte ping-pong banks.
- For each full bank, issues a write request and a sector address, then serves that bank's bytes to the writer through a synchronous read port.
- Sector address auto-increments from a loadable base, so consecutive sectors are written back to back while the next bank fills.

Parameters:
- SEC_BYTES, 512, bytes per sector/bank; must be a power of two.
- AW, 9, address width; log2(SEC_BYTES).
- PAD_BYTE, 8'h00, fill value used when a partial sector is flushed.

Ports:
- SD_clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- base_sec  in  32  first sector address.
- base_load  in  1  pulse; loads base_sec. Honoured only when idle; see Behaviour.
- din  in  8  stream byte.
- din_valid  in  1  byte strobe.
- din_ready  out  1  buffer can accept din this cycle.
- flush  in  1  pulse; pad and commit a partially filled bank.
- wr_sec  out  32  sector address to the writer; stable while write_req is high.
- write_req  out  1  write request to the writer.
- write_done  in  1  writer completion level; rising edge means the sector is finished.
- rd_addr  in  AW  byte index requested by the writer.
- rd_data  out  8  bank byte; 1-cycle registered latency.
- sectors_done  out  32  count of completed sector writes.
- busy  out  1  any bank full, padding in progress, or write outstanding.

Behaviour:
- Reset values: din_ready=1, write_req=0, wr_sec=0, rd_data=0, sectors_done=0, busy=0. Both banks are empty, fill bank=0, fill count=0, next sector=0, write FSM in W_IDLE. Bank RAM contents are don't-care.
- Reset mid-operation aborts everything immediately, including an outstanding request; write_req drops asynchronously.
- Fill side:
  - Byte accepted when din_valid && din_ready.
  - Accepted byte is written to fill_bank[fill_cnt]; fill_cnt increments.
  - When the accepted byte makes fill_cnt reach SEC_BYTES: that bank is marked full, fill_cnt returns to 0, and fill_bank toggles.
  - din_ready = 0 when the current fill bank is full, or while padding.
- Flush:
  - When flush=1, fill_cnt>0 and not already padding, enter padding.
  - Padding writes PAD_BYTE at one byte per cycle until fill_cnt reaches SEC_BYTES, then marks the bank full as above.
  - flush with fill_cnt=0 is ignored. flush during padding is ignored.
  - din_valid during padding is not accepted.
- Write FSM, servicing banks in fill order (oldest full bank first):
  - W_IDLE: if a full bank exists, latch rd_bank, drive wr_sec=next_sec, set write_req=1, go W_BUSY.
  - W_BUSY: hold write_req and wr_sec. A registered copy of write_done detects the rising edge (write_done & ~write_done_q). On that edge, in the same cycle: write_req<=0, clear rd_bank's full flag, next_sec<=next_sec+1 (wraps modulo 2^32), sectors_done<=sectors_done+1, go W_IDLE.
  - A write_done level that is already high on entry to W_BUSY (left over from the previous sector) is not an edge and is ignored.
- Minimum gap between requests: 1 cycle in W_IDLE.
- Read port: rd_data <= bank[rd_bank][rd_addr] every cycle, 1-cycle latency. Addresses are taken modulo SEC_BYTES.
- Simultaneous bank release and bank fill-complete in one cycle: both take effect. The freed bank becomes eligible to fill the next cycle.
- base_load: when the FSM is in W_IDLE, no bank is full, fill_cnt=0 and not padding, set next_sec<=base_sec and sectors_done<=0. Otherwise the pulse is ignored.
- busy = (any full flag) | padding | (FSM != W_IDLE).

Test Plan:
- Reset, then base_load with base_sec=0x0000_1000; stream 512 bytes 0x00..0xFF,0x00..0xFF with din_valid held high -> write_req rises with wr_sec=0x1000. Reading rd_addr 0..511 returns the same pattern one cycle later. Writer edge -> sectors_done=1, write_req=0.
- Stream 1536 bytes with the writer model stalling ~2000 cycles per sector -> din_ready drops after byte 1024. No byte is lost or overwritten. Sectors 0x1000, 0x1001, 0x1002 are written in order, each with correct data.
- Stream 100 bytes, then flush -> din_ready low for 412 cycles. Bank holds bytes 0..99 followed by PAD_BYTE at addresses 100..511. Write request is issued with the next sector.
- flush with fill_cnt=0, and base_load while a write is outstanding -> no request issued; next_sec and sectors_done unchanged.
- write_done still high from the prior sector when the next request starts -> no premature completion. The next rising edge completes the sector.
- Assert rst during W_BUSY with bank 1 half full -> all outputs return to their reset values asynchronously. After release, a fresh 512-byte stream writes a sector at address 0.

Source files
------------

// File: rtl/sd_sector_buffer_if.sv
// Stream-in, sector-write and bank read-back signals of the sector buffer.
interface sd_sector_buffer_if #(parameter int AW = 9);
    logic [31:0]   base_sec;
    logic          base_load;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic          flush;
    logic [31:0]   wr_sec;
    logic          write_req;
    logic          write_done;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [31:0]   sectors_done;
    logic          busy;

    modport slave (
        input  base_sec, base_load, din, din_valid, flush, write_done, rd_addr,
        output din_ready, wr_sec, write_req, rd_data, sectors_done, busy
    );

    modport master (
        output base_sec, base_load, din, din_valid, flush, write_done, rd_addr,
        input  din_ready, wr_sec, write_req, rd_data, sectors_done, busy
    );
endinterface

// File: rtl/sd_sector_buffer.sv
// Ping-pong 2x512B sector buffer feeding an SD block writer; rd_data is 1-cycle registered.
// din_ready drops while the fill bank is full or a flush is padding; writes are served in fill order.
module sd_sector_buffer #(
    parameter int         SEC_BYTES = 512,
    parameter int         AW        = 9,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input logic              SD_clk,
    input logic              rst,
    sd_sector_buffer_if.slave bus
);
    typedef enum logic {W_IDLE, W_BUSY} wstate_t;

    wstate_t       state, state_nxt;
    logic [7:0]    mem [0:2*SEC_BYTES-1];
    logic [1:0]    full;
    logic [1:0]    full_set, full_clr;
    logic          fill_bank;
    logic          rd_bank;
    logic          padding;
    logic          write_done_q;
    logic [AW-1:0] fill_cnt;
    logic [31:0]   next_sec;
    logic          accept, fill_wr, fill_last, start_pad;
    logic          done_rise, start_wr, release_wr, base_ok;
    logic [7:0]    wr_byte;

    assign bus.din_ready = ~full[fill_bank] & ~padding;
    assign accept        = bus.din_valid & bus.din_ready;
    assign fill_wr       = accept | padding;
    assign wr_byte       = padding ? PAD_BYTE : bus.din;
    assign fill_last     = fill_wr && (fill_cnt == AW'(SEC_BYTES - 1));
    // A flush arriving with the byte that completes the bank has nothing left to pad.
    assign start_pad     = bus.flush && !padding && (fill_cnt != '0) && !fill_last;
    assign done_rise     = bus.write_done & ~write_done_q;
    assign base_ok       = (state == W_IDLE) && (full == 2'b00) && (fill_cnt == '0) && !padding;
    assign full_set      = {fill_last & fill_bank, fill_last & ~fill_bank};
    assign full_clr      = {release_wr & rd_bank, release_wr & ~rd_bank};
    assign bus.busy      = (|full) | padding | (state != W_IDLE);

    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) state <= W_IDLE;
        else     state <= state_nxt;
    end

    // Banks fill and drain strictly alternately, so rd_bank always names the oldest full bank.
    always_comb begin
        state_nxt  = state;
        start_wr   = 1'b0;
        release_wr = 1'b0;
        case (state)
            W_IDLE: if (full[rd_bank]) begin
                start_wr  = 1'b1;
                state_nxt = W_BUSY;
            end
            W_BUSY: if (done_rise) begin
                release_wr = 1'b1;
                state_nxt  = W_IDLE;
            end
            default: state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge SD_clk) begin
        if (fill_wr) mem[{fill_bank, fill_cnt}] <= wr_byte;
    end

    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) begin
            full             <= 2'b00;
            fill_bank        <= 1'b0;
            fill_cnt         <= '0;
            padding          <= 1'b0;
            rd_bank          <= 1'b0;
            write_done_q     <= 1'b0;
            next_sec         <= 32'd0;
            bus.wr_sec       <= 32'd0;
            bus.write_req    <= 1'b0;
            bus.sectors_done <= 32'd0;
            bus.rd_data      <= 8'd0;
        end else begin
            write_done_q <= bus.write_done;
            bus.rd_data  <= mem[{rd_bank, bus.rd_addr}];
            full         <= (full & ~full_clr) | full_set;

            if (fill_wr) begin
                if (fill_last) begin
                    fill_cnt  <= '0;
                    fill_bank <= ~fill_bank;
                    padding   <= 1'b0;
                end else begin
                    fill_cnt  <= fill_cnt + 1'b1;
                end
            end
            if (start_pad) padding <= 1'b1;

            if (start_wr) begin
                bus.wr_sec    <= next_sec;
                bus.write_req <= 1'b1;
            end
            if (release_wr) begin
                bus.write_req    <= 1'b0;
                rd_bank          <= ~rd_bank;
                next_sec         <= next_sec + 32'd1;
                bus.sectors_done <= bus.sectors_done + 32'd1;
            end
            if (bus.base_load && base_ok) begin
                next_sec         <= bus.base_sec;
                bus.sectors_done <= 32'd0;
            end
        end
    end
endmodule
